// File: rtl/aircon_ctrl.sv
// Thermostat FSM (IDLE/HEAT/COOL) with run-time thresholds, mode gating and config check; optional dwell lockout via AIRCON_MIN_DWELL_EN.
// Latency: one edge from sampled inputs to registered outputs; no backpressure, a new sample is taken every cycle.
module aircon_ctrl #(
    parameter int TEMP_W    = 5,
    parameter int CNT_W     = 8,
    parameter int MIN_DWELL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TEMP_W-1:0] temp,
    input  logic [TEMP_W-1:0] heat_on,
    input  logic [TEMP_W-1:0] heat_off,
    input  logic [TEMP_W-1:0] cool_off,
    input  logic [TEMP_W-1:0] cool_on,
    input  logic [1:0]        mode,
    output logic              heating,
    output logic              cooling,
    output logic [1:0]        state,
    output logic              cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HEAT = 2'b01,
        ST_COOL = 2'b10
    } state_t;

    if (MIN_DWELL < 1 || MIN_DWELL > (2**CNT_W) - 1) begin : g_bad_dwell
        $error("aircon_ctrl: MIN_DWELL out of range for CNT_W");
    end

    state_t r_state;
    state_t w_next;
    logic   r_heating;
    logic   r_cooling;
    logic   r_cfg_err;
    logic   w_cfg_ok;
    logic   w_heat_en;
    logic   w_cool_en;
    logic   w_dwell_ok;

    assign w_cfg_ok  = (heat_on < heat_off) && (heat_off <= cool_off) && (cool_off < cool_on);
    assign w_heat_en = mode[0];
    assign w_cool_en = mode[1];

`ifdef AIRCON_MIN_DWELL_EN
    localparam logic [CNT_W-1:0] DWELL_SAT  = CNT_W'(MIN_DWELL);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(MIN_DWELL - 1);

    // r_dwell counts completed cycles before the current one, so the
    // current cycle finishes the dwell once r_dwell reaches MIN_DWELL-1.
    logic [CNT_W-1:0] r_dwell;

    assign w_dwell_ok = (r_dwell >= DWELL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell <= DWELL_SAT;
        end else if (w_next != r_state) begin
            r_dwell <= '0;
        end else if (r_dwell < DWELL_SAT) begin
            r_dwell <= r_dwell + 1'b1;
        end
    end
`else
    assign w_dwell_ok = 1'b1;
`endif

    always_comb begin
        w_next = r_state;
        if (!w_cfg_ok) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_dwell_ok) begin
                        if (w_heat_en && (temp <= heat_on)) begin
                            w_next = ST_HEAT;
                        end else if (w_cool_en && (temp >= cool_on)) begin
                            w_next = ST_COOL;
                        end
                    end
                end
                ST_HEAT: begin
                    if (!w_heat_en) begin
                        w_next = ST_IDLE;
                    end else if (w_dwell_ok && (temp >= heat_off)) begin
                        w_next = ST_IDLE;
                    end
                end
                ST_COOL: begin
                    if (!w_cool_en) begin
                        w_next = ST_IDLE;
                    end else if (w_dwell_ok && (temp <= cool_off)) begin
                        w_next = ST_IDLE;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they track r_state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_heating <= 1'b0;
            r_cooling <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_heating <= (w_next == ST_HEAT);
            r_cooling <= (w_next == ST_COOL);
            r_cfg_err <= !w_cfg_ok;
        end
    end

    assign state   = r_state;
    assign heating = r_heating;
    assign cooling = r_cooling;
    assign cfg_err = r_cfg_err;

endmodule
